// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA sync generator.
// Defaults describe 640x480 @ 60 Hz with a 25 MHz pixel rate.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1024;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int h_total(input int visible, input int front,
                                 input int sync_w, input int back);
    return visible + front + sync_w + back;
  endfunction

  function automatic int v_total(input int visible, input int front,
                                 input int sync_w, input int back);
    return visible + front + sync_w + back;
  endfunction

  // True when pos lies in [lo, lo+len).
  function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                     input int lo, input int len);
    return (int'(pos) >= lo) && (int'(pos) < lo + len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around position counter used for both raster axes; wrap_o flags the
// last position so the caller can chain the next axis.
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               advance_i,
  input  logic [COORD_W-1:0] limit_i,
  output logic [COORD_W-1:0] count_o,
  output logic               wrap_o
);

  logic [COORD_W-1:0] count_q;
  logic [COORD_W-1:0] count_d;

  assign wrap_o  = (count_q == limit_i);
  assign count_o = count_q;

  // Next count: hold, step, or wrap to zero at the limit.
  always_comb begin
    count_d = count_q;
    if (advance_i) begin
      if (wrap_o) begin
        count_d = {COORD_W{1'b0}};
      end else begin
        count_d = count_q + COORD_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {COORD_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel divider, H/V counters, registered coordinate
// decodes, and sync outputs delayed to match the downstream RGB register.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int H_VISIBLE    = DEF_H_VISIBLE,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_VISIBLE    = DEF_V_VISIBLE,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK,
  parameter int HSYNC_ACTIVE = 0,
  parameter int VSYNC_ACTIVE = 0,
  parameter int SYNC_DELAY   = 1
) (
  input  logic               clock,
  input  logic               reset,
  output logic               pixel_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL  = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL  = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;

  localparam logic [3:0]         DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
  localparam logic               HS_ON    = 1'(HSYNC_ACTIVE);
  localparam logic               VS_ON    = 1'(VSYNC_ACTIVE);

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_chk
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $error("vga_sync_gen: CLK_DIV must be 1..16");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_dly_chk
    $error("vga_sync_gen: SYNC_DELAY must be 0..4");
  end

  logic [3:0]         div_cnt_q, div_cnt_d;
  logic               tick_s, v_adv_s;
  logic               h_wrap_s, v_wrap_s;
  logic [COORD_W-1:0] h_cnt_s, v_cnt_s;

  logic               pixel_tick_q;
  logic [COORD_W-1:0] pixel_x_q, pixel_y_q;
  logic               video_on_q, video_on_d;
  logic               line_wrap_q, line_wrap_d;
  logic               frame_wrap_q, frame_wrap_d;
  logic               line_start_q, frame_start_q;
  logic               hs_raw_d, vs_raw_d;
  logic [SYNC_DELAY:0] hs_pipe_q, hs_pipe_d;
  logic [SYNC_DELAY:0] vs_pipe_q, vs_pipe_d;

  assign tick_s  = (div_cnt_q == DIV_LAST);
  assign v_adv_s = tick_s & h_wrap_s;

  vga_axis_counter u_h_cnt (
    .clk_i     (clock),
    .rst_i     (reset),
    .advance_i (tick_s),
    .limit_i   (H_LAST),
    .count_o   (h_cnt_s),
    .wrap_o    (h_wrap_s)
  );

  vga_axis_counter u_v_cnt (
    .clk_i     (clock),
    .rst_i     (reset),
    .advance_i (v_adv_s),
    .limit_i   (V_LAST),
    .count_o   (v_cnt_s),
    .wrap_o    (v_wrap_s)
  );

  // Stage 0 of each sync pipe is the raw decode, aligned with pixel_x/pixel_y.
  if (SYNC_DELAY == 0) begin : g_no_dly
    assign hs_pipe_d = hs_raw_d;
    assign vs_pipe_d = vs_raw_d;
  end else begin : g_dly
    assign hs_pipe_d = {hs_pipe_q[SYNC_DELAY-1:0], hs_raw_d};
    assign vs_pipe_d = {vs_pipe_q[SYNC_DELAY-1:0], vs_raw_d};
  end

  // Divider step and counter decodes feeding the output register stage.
  always_comb begin
    div_cnt_d    = div_cnt_q;
    video_on_d   = 1'b0;
    hs_raw_d     = ~HS_ON;
    vs_raw_d     = ~VS_ON;
    line_wrap_d  = tick_s & h_wrap_s;
    frame_wrap_d = tick_s & h_wrap_s & v_wrap_s;

    if (tick_s) begin
      div_cnt_d = 4'd0;
    end else begin
      div_cnt_d = div_cnt_q + 4'd1;
    end

    video_on_d = (h_cnt_s < H_VIS) && (v_cnt_s < V_VIS);

    if (in_window(h_cnt_s, HS_START, H_SYNC)) begin
      hs_raw_d = HS_ON;
    end else begin
      hs_raw_d = ~HS_ON;
    end

    if (in_window(v_cnt_s, VS_START, V_SYNC)) begin
      vs_raw_d = VS_ON;
    end else begin
      vs_raw_d = ~VS_ON;
    end
  end

  // Divider and output registers; the wrap flags delay start pulses so they
  // land in the first clock that shows the new coordinate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= 4'd0;
      pixel_tick_q  <= 1'b0;
      pixel_x_q     <= {COORD_W{1'b0}};
      pixel_y_q     <= {COORD_W{1'b0}};
      video_on_q    <= 1'b0;
      line_wrap_q   <= 1'b0;
      frame_wrap_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_pipe_q     <= {(SYNC_DELAY+1){~HS_ON}};
      vs_pipe_q     <= {(SYNC_DELAY+1){~VS_ON}};
    end else begin
      div_cnt_q     <= div_cnt_d;
      pixel_tick_q  <= tick_s;
      pixel_x_q     <= h_cnt_s;
      pixel_y_q     <= v_cnt_s;
      video_on_q    <= video_on_d;
      line_wrap_q   <= line_wrap_d;
      frame_wrap_q  <= frame_wrap_d;
      line_start_q  <= line_wrap_q;
      frame_start_q <= frame_wrap_q;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
    end
  end

  assign pixel_tick  = pixel_tick_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hsync       = hs_pipe_q[SYNC_DELAY];
  assign vsync       = vs_pipe_q[SYNC_DELAY];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations checked every clock against a
// timing model derived from elapsed clocks since reset release.
module tb_vga_sync_gen;

  typedef struct packed {
    int div_n; int hv; int hf; int hsw; int hb;
    int vv;    int vf; int vsw; int vb;
    int act_h; int act_v; int dly;
  } cfg_t;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  typedef struct {
    int   e;
    obs_t exp;
  } vec_t;

  localparam cfg_t CA = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
  localparam cfg_t CB = '{1, 8, 2, 3, 2, 6, 1, 2, 2, 0, 0, 0};
  localparam cfg_t CC = '{3, 5, 1, 2, 1, 4, 1, 1, 2, 1, 1, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_tick, a_vo, a_hs, a_vs, a_ls, a_fs;
  logic b_tick, b_vo, b_hs, b_vs, b_ls, b_fs;
  logic c_tick, c_vo, c_hs, c_vs, c_ls, c_fs;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;

  vga_sync_gen #(.CLK_DIV(CA.div_n), .H_VISIBLE(CA.hv), .H_FRONT(CA.hf), .H_SYNC(CA.hsw),
    .H_BACK(CA.hb), .V_VISIBLE(CA.vv), .V_FRONT(CA.vf), .V_SYNC(CA.vsw), .V_BACK(CA.vb),
    .HSYNC_ACTIVE(CA.act_h), .VSYNC_ACTIVE(CA.act_v), .SYNC_DELAY(CA.dly)) u_a (
    .clock(clk), .reset(rst), .pixel_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs));

  vga_sync_gen #(.CLK_DIV(CB.div_n), .H_VISIBLE(CB.hv), .H_FRONT(CB.hf), .H_SYNC(CB.hsw),
    .H_BACK(CB.hb), .V_VISIBLE(CB.vv), .V_FRONT(CB.vf), .V_SYNC(CB.vsw), .V_BACK(CB.vb),
    .HSYNC_ACTIVE(CB.act_h), .VSYNC_ACTIVE(CB.act_v), .SYNC_DELAY(CB.dly)) u_b (
    .clock(clk), .reset(rst), .pixel_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs));

  vga_sync_gen #(.CLK_DIV(CC.div_n), .H_VISIBLE(CC.hv), .H_FRONT(CC.hf), .H_SYNC(CC.hsw),
    .H_BACK(CC.hb), .V_VISIBLE(CC.vv), .V_FRONT(CC.vf), .V_SYNC(CC.vsw), .V_BACK(CC.vb),
    .HSYNC_ACTIVE(CC.act_h), .VSYNC_ACTIVE(CC.act_v), .SYNC_DELAY(CC.dly)) u_c (
    .clock(clk), .reset(rst), .pixel_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y),
    .video_on(c_vo), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs));

  int n_cmp  = 0;
  int n_fail = 0;
  int e      = 0;
  int cyc    = 0;
  obs_t oa, ob, oc;

  int a_last_ls = -1, a_hs_run = 0, a_vo_run = 0;
  int b_last_fs = -1, b_vs_run = 0, c_last_fs = -1;

  function automatic obs_t mk(logic t, logic [9:0] x, logic [9:0] y, logic vo,
                              logic hs, logic vs, logic ls, logic fs);
    obs_t o;
    o.tick = t; o.x = x; o.y = y; o.vo = vo;
    o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("tick=%b x=%0d y=%0d vo=%b hs=%b vs=%b ls=%b fs=%b",
                     o.tick, o.x, o.y, o.vo, o.hs, o.vs, o.ls, o.fs);
  endfunction

  // Raster position (pixel index within the frame) shown k clocks after release.
  function automatic int pos_at(cfg_t c, int k);
    int total;
    total = (c.hv + c.hf + c.hsw + c.hb) * (c.vv + c.vf + c.vsw + c.vb);
    if (k < 1) return -1;
    return ((k - 1) / c.div_n) % total;
  endfunction

  function automatic obs_t model(cfg_t c, int k, logic in_rst);
    obs_t o;
    int ht, p, pp, px, py, d;
    ht = c.hv + c.hf + c.hsw + c.hb;
    o = '0;
    o.hs = ~c.act_h[0];
    o.vs = ~c.act_v[0];
    if (in_rst || k < 1) return o;
    p  = pos_at(c, k);
    px = p % ht;
    py = p / ht;
    pp = pos_at(c, k - 1);
    o.tick = (k % c.div_n == 0);
    o.x    = 10'(px);
    o.y    = 10'(py);
    o.vo   = (px < c.hv) && (py < c.vv);
    o.ls   = (k >= 2) && (px == 0) && (pp % ht != 0);
    o.fs   = (k >= 2) && (p == 0) && (pp != 0);
    d = k - c.dly;
    if (d >= 1) begin
      p  = pos_at(c, d);
      px = p % ht;
      py = p / ht;
      if (px >= c.hv + c.hf && px < c.hv + c.hf + c.hsw) o.hs = c.act_h[0];
      if (py >= c.vv + c.vf && py < c.vv + c.vf + c.vsw) o.vs = c.act_v[0];
    end
    return o;
  endfunction

  task automatic check_obs(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s e=%0d got {%s} want {%s}", nm, e, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s e=%0d got %0d want %0d", nm, e, act, exp);
    end
  endtask

  // One clock: count edges since release, sample after the falling edge, check.
  task automatic step();
    @(posedge clk);
    if (rst) e = 0; else e = e + 1;
    cyc = cyc + 1;
    @(negedge clk);
    #1;
    oa = mk(a_tick, a_x, a_y, a_vo, a_hs, a_vs, a_ls, a_fs);
    ob = mk(b_tick, b_x, b_y, b_vo, b_hs, b_vs, b_ls, b_fs);
    oc = mk(c_tick, c_x, c_y, c_vo, c_hs, c_vs, c_ls, c_fs);
    check_obs("dut_a_model", oa, model(CA, e, rst));
    check_obs("dut_b_model", ob, model(CB, e, rst));
    check_obs("dut_c_model", oc, model(CC, e, rst));
    if (rst) begin
      a_last_ls = -1; a_hs_run = 0; a_vo_run = 0;
      b_last_fs = -1; b_vs_run = 0; c_last_fs = -1;
    end else begin
      if (a_ls) begin
        if (a_last_ls >= 0) check_int("a_line_period", cyc - a_last_ls, 1600);
        a_last_ls = cyc;
      end
      if (!a_hs) a_hs_run++;
      else begin
        if (a_hs_run > 0) check_int("a_hsync_low_clocks", a_hs_run, 192);
        a_hs_run = 0;
      end
      if (a_vo) a_vo_run++;
      else begin
        if (a_vo_run > 0) check_int("a_video_on_clocks", a_vo_run, 1280);
        a_vo_run = 0;
      end
      if (b_fs) begin
        if (b_last_fs >= 0) check_int("b_frame_period", cyc - b_last_fs, 165);
        b_last_fs = cyc;
      end
      if (!b_vs) b_vs_run++;
      else begin
        if (b_vs_run > 0) check_int("b_vsync_low_clocks", b_vs_run, 30);
        b_vs_run = 0;
      end
      if (c_fs) begin
        if (c_last_fs >= 0) check_int("c_frame_period", cyc - c_last_fs, 216);
        c_last_fs = cyc;
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    int guard;
    logic found;

    // Hand-derived points for the default 640x480 instance, by clocks since release.
    tbl.push_back('{1,    mk(1'b0, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{2,    mk(1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{3,    mk(1'b0, 10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{4,    mk(1'b1, 10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{1280, mk(1'b1, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{1281, mk(1'b0, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{1313, mk(1'b0, 10'd656, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{1314, mk(1'b1, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{1505, mk(1'b0, 10'd752, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{1506, mk(1'b1, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{1600, mk(1'b1, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)});
    tbl.push_back('{1601, mk(1'b0, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0)});
    tbl.push_back('{1602, mk(1'b1, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});

    rst = 1'b1;
    step();
    check_obs("reset_state_a", oa, mk(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    step();
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      guard = 0;
      while (e < tbl[i].e && guard < 4000) begin
        step();
        guard++;
      end
      check_obs($sformatf("vec_e%0d", tbl[i].e), oa, tbl[i].exp);
    end

    repeat (3400) step();

    // Mid-frame reset on the small raster, held three clocks.
    found = 1'b0;
    guard = 0;
    while (!found && guard < 400) begin
      step();
      guard++;
      if (b_x == 10'd5 && b_y == 10'd3) found = 1'b1;
    end
    check_int("b_wait_pos_5_3", int'(found), 1);
    do_reset(3);
    repeat (400) step();

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(50, 2500)) step();
      do_reset($urandom_range(1, 4));
    end
    repeat (1700) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
